// File: rtl/ethpipe_tx_port.sv
// ethpipe GMII transmitter: reads one frame from a TX slot RAM and sends
// preamble, SFD, frame bytes and IFG, then reports slot completion.
module ethpipe_tx_port #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int MAX_LEN      = 1518
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] global_counter,
    input  logic        tx_req,
    output logic        tx_complete,
    output logic        tx_error,
    output logic        tx_busy,
    output logic [10:0] slot_tx_eth_address,
    input  logic [31:0] slot_tx_eth_q,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT,
        S_PRE,
        S_DATA,
        S_IFG,
        S_DONE
    } state_t;

    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN);
    localparam logic [10:0] IFG_LAST = 11'(IFG_LEN - 1);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);

    state_t      state, state_d;
    logic [10:0] cnt, cnt_d;
    logic [10:0] addr, addr_d;
    logic        armed, armed_d;
    logic        err, err_d;
    logic [31:0] ts_lo, ts_lo_d;
    logic [31:0] ts_hi, ts_hi_d;
    logic [10:0] len, len_d;
    logic [31:0] wbuf, wbuf_d;
    logic [7:0]  txd_d;
    logic        en_d;

    logic [63:0] ts;
    logic [10:0] q_len;
    logic        launch;
    logic        len_bad;

    assign ts      = {ts_hi, ts_lo};
    assign q_len   = slot_tx_eth_q[26:16];
    assign launch  = (ts == 64'd0) || (global_counter >= ts);
    assign len_bad = (q_len == 11'd0) || (q_len > MAX_L);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr;
        armed_d = armed;
        err_d   = err;
        ts_lo_d = ts_lo;
        ts_hi_d = ts_hi;
        len_d   = len;
        wbuf_d  = wbuf;
        txd_d   = 8'h00;
        en_d    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!tx_req) begin
                    armed_d = 1'b1;
                end else if (armed) begin
                    state_d = S_HDR;
                    cnt_d   = 11'd0;
                    addr_d  = 11'd0;
                    armed_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_HDR: begin
                // q lags the address by one cycle: word0 at cnt 1, word3 at cnt 4
                cnt_d  = cnt + 11'd1;
                addr_d = (cnt < 11'd3) ? cnt + 11'd1 : 11'd4;
                if (cnt == 11'd1) ts_lo_d = slot_tx_eth_q;
                if (cnt == 11'd2) ts_hi_d = slot_tx_eth_q;
                if (cnt == 11'd4) begin
                    len_d = q_len;
                    cnt_d = 11'd0;
                    if (len_bad) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (launch) begin
                        state_d = S_PRE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = 11'd0;
                if (global_counter >= ts) state_d = S_PRE;
            end
            S_PRE: begin
                if (cnt == PRE_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = 11'd0;
                    wbuf_d  = slot_tx_eth_q;
                    addr_d  = addr + 11'd1;
                end else begin
                    cnt_d = cnt + 11'd1;
                end
            end
            S_DATA: begin
                if (cnt == len - 11'd1) begin
                    state_d = S_IFG;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt + 11'd1;
                    // next word has been stable on q for several cycles
                    if (cnt[1:0] == 2'd3) begin
                        wbuf_d = slot_tx_eth_q;
                        addr_d = addr + 11'd1;
                    end
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt + 11'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 11'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // wire outputs are registered from the upcoming state
        unique case (state_d)
            S_PRE: begin
                en_d  = 1'b1;
                txd_d = (cnt_d == PRE_LAST) ? 8'hD5 : 8'h55;
            end
            S_DATA: begin
                en_d  = 1'b1;
                txd_d = wbuf_d[{cnt_d[1:0], 3'b000} +: 8];
            end
            default: begin
                en_d  = 1'b0;
                txd_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            cnt        <= 11'd0;
            addr       <= 11'd0;
            armed      <= 1'b1;
            err        <= 1'b0;
            ts_lo      <= 32'd0;
            ts_hi      <= 32'd0;
            len        <= 11'd0;
            wbuf       <= 32'd0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            addr       <= addr_d;
            armed      <= armed_d;
            err        <= err_d;
            ts_lo      <= ts_lo_d;
            ts_hi      <= ts_hi_d;
            len        <= len_d;
            wbuf       <= wbuf_d;
            gmii_txd   <= txd_d;
            gmii_tx_en <= en_d;
        end
    end

    assign slot_tx_eth_address = addr;
    assign tx_complete         = (state == S_DONE);
    assign tx_error            = (state == S_DONE) && err;
    assign tx_busy             = (state != S_IDLE);

endmodule

// File: tb/tb_ethpipe_tx_port.sv
// Directed bench for ethpipe_tx_port: slot RAM model, wire monitor,
// hand-computed expectations.
module tb_ethpipe_tx_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] gc = 64'd0;
    logic        gc_set = 1'b0;
    logic [63:0] gc_val = 64'd0;
    logic        tx_req = 1'b0;
    logic        tx_complete;
    logic        tx_error;
    logic        tx_busy;
    logic [10:0] addr;
    logic [31:0] q = 32'd0;
    logic [7:0]  txd;
    logic        tx_en;

    logic [31:0] mem [0:2047];
    logic [7:0]  fb  [0:2047];

    int n_chk = 0;
    int n_fail = 0;

    int cyc = 0;
    logic [7:0] wire_q [$];
    int n_en = 0, n_done = 0, n_ep = 0, n_txd_bad = 0, n_orphan = 0;
    int first_cyc = 0, last_en_cyc = 0, done_cyc = 0;
    int gap = 0, last_gap = 0;
    logic [63:0] first_gc = 64'd0;
    logic prev_en = 1'b0;

    int s_w0, s_d0, s_e0, s_en0, s_rcyc;

    ethpipe_tx_port dut (
        .gmii_tx_clk         (clk),
        .sys_rst_n           (rst_n),
        .global_counter      (gc),
        .tx_req              (tx_req),
        .tx_complete         (tx_complete),
        .tx_error            (tx_error),
        .tx_busy             (tx_busy),
        .slot_tx_eth_address (addr),
        .slot_tx_eth_q       (q),
        .gmii_txd            (txd),
        .gmii_tx_en          (tx_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        q   <= mem[addr];
        cyc <= cyc + 1;
        if (gc_set) gc <= gc_val;
        else        gc <= gc + 64'd1;
    end

    always @(negedge clk) begin
        if (tx_en) begin
            wire_q.push_back(txd);
            if (!prev_en) begin
                first_cyc = cyc;
                first_gc  = gc;
                last_gap  = gap;
            end
            gap = 0;
            last_en_cyc = cyc;
            n_en++;
        end else begin
            gap++;
            if (txd != 8'h00) n_txd_bad++;
        end
        if (tx_complete) begin
            n_done++;
            done_cyc = cyc;
        end
        if (tx_error) n_ep++;
        if (tx_error && !tx_complete) n_orphan++;
        prev_en = tx_en;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [63:0] ts, input int len,
                        input logic [7:0] base);
        int nb;
        nb = (len > 1518) ? 1518 : len;
        mem[0] = ts[31:0];
        mem[1] = ts[63:32];
        mem[2] = 32'hDEADBEEF;
        mem[3] = {5'b11111, 11'(len), 16'h5A5A};
        for (int w = 4; w < 4 + nb / 4 + 4; w++) mem[w] = 32'hA5A5A5A5;
        for (int i = 0; i < nb; i++) begin
            fb[i] = base + 8'(i);
            mem[4 + i / 4][8 * (i % 4) +: 8] = fb[i];
        end
    endtask

    task automatic start(input logic do_gc);
        @(negedge clk);
        s_w0   = wire_q.size();
        s_d0   = n_done;
        s_e0   = n_ep;
        s_en0  = n_en;
        s_rcyc = cyc;
        tx_req = 1'b1;
        if (do_gc) begin
            gc_val = 64'd900;
            gc_set = 1'b1;
        end
        @(negedge clk);
        gc_set = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (n_done == s_d0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 64'(n_done > s_d0), 64'd1);
    endtask

    task automatic release_req();
        @(negedge clk);
        tx_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int len);
        int n, nbad;
        logic [7:0] e;
        n = wire_q.size() - s_w0;
        nbad = 0;
        for (int i = 0; i < n; i++) begin
            if (i < 7) e = 8'h55;
            else if (i == 7) e = 8'hD5;
            else if (i - 8 < len) e = fb[i - 8];
            else e = 8'hxx;
            if (wire_q[s_w0 + i] !== e) nbad++;
        end
        chk({tag, "_wire_len"}, 64'(n), 64'(len + 8));
        chk({tag, "_bytes_bad"}, 64'(nbad), 64'd0);
        chk({tag, "_complete"}, 64'(n_done - s_d0), 64'd1);
        chk({tag, "_error"}, 64'(n_ep - s_e0), 64'd0);
    endtask

    task automatic bad_len(input string tag, input int len);
        load(64'd0, len, 8'h10);
        start(1'b0);
        wait_done(tag);
        repeat (2) @(negedge clk);
        chk({tag, "_complete"}, 64'(n_done - s_d0), 64'd1);
        chk({tag, "_error"}, 64'(n_ep - s_e0), 64'd1);
        chk({tag, "_no_tx_en"}, 64'(n_en - s_en0), 64'd0);
        release_req();
    endtask

    initial begin
        int k;
        logic [7:0] lastb;
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_tx_en", 64'(tx_en), 64'd0);
        chk("rst_txd", 64'(txd), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_complete", 64'(tx_complete), 64'd0);
        chk("rst_error", 64'(tx_error), 64'd0);
        chk("rst_busy", 64'(tx_busy), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 64-byte immediate frame, tx_req held afterwards
        load(64'd0, 64, 8'h00);
        start(1'b0);
        wait_done("f64");
        repeat (2) @(negedge clk);
        check_frame("f64", 64);
        chk("f64_latency", 64'(first_cyc - s_rcyc), 64'd6);
        chk("f64_ifg", 64'(done_cyc - last_en_cyc), 64'd13);
        s_en0 = n_en;
        s_d0  = n_done;
        repeat (60) @(negedge clk);
        chk("hold_no_tx_en", 64'(n_en - s_en0), 64'd0);
        chk("hold_no_complete", 64'(n_done - s_d0), 64'd0);
        release_req();

        // delayed launch at ts=1000
        load(64'd1000, 8, 8'h40);
        start(1'b1);
        wait_done("ts1000");
        repeat (2) @(negedge clk);
        check_frame("ts1000", 8);
        chk("ts1000_launch_gc",
            64'(first_gc >= 64'd1000 && first_gc <= 64'd1001), 64'd1);
        release_req();

        bad_len("len0", 0);
        bad_len("len1519", 1519);

        // non-multiple-of-4 length
        load(64'd0, 61, 8'h80);
        start(1'b0);
        wait_done("len61");
        repeat (2) @(negedge clk);
        check_frame("len61", 61);
        if (wire_q.size() > s_w0 + 68) lastb = wire_q[s_w0 + 68];
        else lastb = 8'hxx;
        chk("len61_last_byte", 64'(lastb), 64'hBC);
        release_req();

        // back-to-back requests
        load(64'd0, 20, 8'h20);
        start(1'b0);
        wait_done("b2b_a");
        release_req();
        load(64'd0, 24, 8'h60);
        start(1'b0);
        wait_done("b2b_b");
        repeat (2) @(negedge clk);
        check_frame("b2b_b", 24);
        chk("b2b_gap_ge_12", 64'(last_gap >= 12), 64'd1);
        release_req();

        // reset in the middle of the data phase
        load(64'd0, 64, 8'hC0);
        start(1'b0);
        k = 0;
        while (wire_q.size() < s_w0 + 20 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reached_data", 64'(wire_q.size() >= s_w0 + 20), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_en", 64'(tx_en), 64'd0);
        chk("mid_rst_busy", 64'(tx_busy), 64'd0);
        tx_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        load(64'd0, 33, 8'hE0);
        start(1'b0);
        wait_done("post_rst");
        repeat (2) @(negedge clk);
        check_frame("post_rst", 33);
        release_req();

        chk("txd_zero_when_idle", 64'(n_txd_bad), 64'd0);
        chk("error_without_complete", 64'(n_orphan), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ethpipe_tx_port.md
Name: ethpipe_tx_port

Overview:
- GMII transmitter and the TX counterpart of the ethpipe RX slot writer.
- Reads one frame from a TX slot RAM. The slot layout mirrors the RX slot: words 0/1 hold a 64-bit launch time, word 2 is reserved, and word 3[26:16] holds the frame length in bytes including FCS. Frame bytes start at word 4.
- Emits the preamble/SFD, the frame bytes verbatim (FCS is supplied by the host), and the inter-frame gap, then signals completion back toward the PCIe side.
- Runs entirely in the gmii_tx_clk domain. Clock-domain crossing of tx_req/tx_complete is external.

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes before SFD 0xD5.
- IFG_LEN, 12: idle cycles after the last frame byte.
- MAX_LEN, 1518: largest legal length field value.

Ports:
- gmii_tx_clk  in  1  sole clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- global_counter  in  64  free-running timestamp, same domain.
- tx_req  in  1  level: slot holds a frame ready to send.
- tx_complete  out  1  one-cycle pulse: slot consumed (sent or rejected).
- tx_error  out  1  one-cycle pulse with tx_complete when the length is illegal.
- tx_busy  out  1  high in every state except IDLE.
- slot_tx_eth_address  out  11  slot RAM word address.
- slot_tx_eth_q  in  32  slot RAM read data, valid exactly 1 cycle after the address.
- gmii_txd  out  8  transmit data, registered.
- gmii_tx_en  out  1  transmit enable, registered.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, armed=1, gmii_tx_en=0, gmii_txd=0x00, slot_tx_eth_address=0, tx_complete=0, tx_error=0, tx_busy=0.
- Reset mid-frame aborts immediately. gmii_tx_en drops on reset assertion; no partial IFG is sent.
- States: IDLE -> HDR -> (WAIT | PRE | DONE) -> DATA -> IFG -> DONE -> IDLE.
- IDLE:
  - If tx_req=1 and armed=1: go to HDR and drive address 0.
  - armed clears on leaving IDLE and sets again only when tx_req is sampled 0 in IDLE. One frame per tx_req assertion; a held-high tx_req never retransmits.
- HDR:
  - Issues addresses 1, 2, 3 on consecutive cycles and captures q for words 0, 1, 3. Word 2 is ignored.
  - len = word3[26:16]. ts = {word1, word0}.
  - If len==0 or len>MAX_LEN: go to DONE with tx_error.
  - Else if ts==0 or global_counter>=ts (unsigned 64-bit): go to PRE.
  - Else: go to WAIT.
- WAIT: holds until global_counter>=ts, then goes to PRE. There is no timeout; only reset exits.
- Launch latency: with an immediate launch, gmii_tx_en first rises exactly 6 cycles after the IDLE cycle that samples tx_req.
- PRE: PREAMBLE_LEN cycles of 0x55, then 1 cycle of 0xD5, all with tx_en=1.
- DATA:
  - Outputs len bytes on consecutive cycles with tx_en=1 and no gaps.
  - Byte i comes from word 4+(i>>2), lane i[1:0]; lane 0 = q[7:0], lane 3 = q[31:24].
  - Words are prefetched to absorb the 1-cycle RAM latency. Reading beyond word 4+((len-1)>>2) is permitted; those bytes are never driven.
- IFG: tx_en=0, txd=0x00 for IFG_LEN cycles.
- DONE: tx_complete=1 for one cycle; tx_error=1 in the same cycle if the length was rejected. Next state is IDLE.
- The byte counter is 11 bits; len=MAX_LEN never wraps it.
- gmii_txd is 0x00 whenever tx_en=0.
- If tx_req drops after leaving IDLE, the frame still completes.

Test Plan:
- 64-byte frame, ts=0, bytes 0x00..0x3F, tx_req held high -> tx_en rises 6 cycles after the req sample. Wire shows 7x55, D5, then 00..3F (72 tx_en cycles), then 12 idle cycles. One tx_complete pulse, tx_error=0, and no second frame until tx_req goes low then high.
- ts=1000 with global_counter=900 at request -> the first 0x55 appears when global_counter>=1000. No tx_en before that.
- len=0, then len=1519 -> no tx_en activity. tx_complete and tx_error pulse together once per request.
- len=61 (non-multiple of 4) -> last byte is taken from word 19 lane 0, and 61 data cycles are seen.
- Two back-to-back requests -> second preamble starts no earlier than 12 idle cycles after the first frame.
- sys_rst_n asserted mid-DATA -> tx_en=0 immediately. After release, a fresh request sends a complete, correct frame.
